// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM: steps each instruction through FETCH/DECODE/EXEC/MEM/WB
// (plus MULDIV). It handles imem/dmem handshakes, a memory timeout and illegal-opcode traps.
module multicycle_control_unit #(
    parameter int OPCODE_W    = 5,
    parameter int MULDIV_LAT  = 4,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [4:0]          aluop,
    input  logic                instr_valid,
    input  logic                mem_ready,
    input  logic                branch_taken,
    input  logic                bex_cond,
    output logic                ir_write,
    output logic                pc_write,
    output logic [1:0]          pc_src,
    output logic                reg_write,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                alu_src_b,
    output logic                link_write,
    output logic                status_write,
    output logic                mem_read,
    output logic                mem_write,
    output logic                muldiv_start,
    output logic                illegal_op,
    output logic                mem_fault,
    output logic                busy,
    output logic [2:0]          state
);
    localparam int CNT_MAX = (MULDIV_LAT > MEM_TIMEOUT) ? MULDIV_LAT : MEM_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] MD_LOAD  = CNT_W'(MULDIV_LAT - 1);
    localparam logic [CNT_W-1:0] MEM_LOAD = CNT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_MULDIV = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [OPCODE_W-1:0] op_q, op_d;
    logic [4:0]          aluop_q, aluop_d;

    // Opcode bits above the 5-bit field must all be zero for a legal instruction.
    logic       hi_zero;
    logic [4:0] op5;
    logic       is_r, is_md, is_j, is_br, is_jal, is_jr, is_addi, is_sw, is_lw, is_setx, is_bex, legal;

    assign hi_zero = ((op_q >> 5) == '0);
    assign op5     = op_q[4:0];
    assign is_r    = hi_zero && (op5 == 5'b00000);
    assign is_md   = is_r && (aluop_q[4:1] == 4'b0011);
    assign is_j    = hi_zero && (op5 == 5'b00001);
    assign is_br   = hi_zero && ((op5 == 5'b00010) || (op5 == 5'b00110));
    assign is_jal  = hi_zero && (op5 == 5'b00011);
    assign is_jr   = hi_zero && (op5 == 5'b00100);
    assign is_addi = hi_zero && (op5 == 5'b00101);
    assign is_sw   = hi_zero && (op5 == 5'b00111);
    assign is_lw   = hi_zero && (op5 == 5'b01000);
    assign is_setx = hi_zero && (op5 == 5'b10101);
    assign is_bex  = hi_zero && (op5 == 5'b10110);
    assign legal   = is_r | is_j | is_br | is_jal | is_jr | is_addi | is_sw | is_lw | is_setx | is_bex;

    assign state = state_q;
    assign busy  = (state_q != S_FETCH);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            op_q    <= '0;
            aluop_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            aluop_q <= aluop_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        aluop_d      = aluop_q;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 2'd0;
        reg_write    = 1'b0;
        reg_dst      = 1'b0;
        mem_to_reg   = 1'b0;
        alu_src_b    = 1'b0;
        link_write   = 1'b0;
        status_write = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        muldiv_start = 1'b0;
        illegal_op   = 1'b0;
        mem_fault    = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (instr_valid) begin
                    ir_write = 1'b1;
                    op_d     = opcode;
                    aluop_d  = aluop;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!legal) begin
                    illegal_op = 1'b1;
                    pc_write   = 1'b1;
                    state_d    = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_src_b = is_addi | is_lw | is_sw;
                if (is_md) begin
                    muldiv_start = 1'b1;
                    cnt_d        = MD_LOAD;
                    state_d      = S_MULDIV;
                end else if (is_r || is_addi) begin
                    state_d = S_WB;
                end else if (is_lw || is_sw) begin
                    cnt_d   = MEM_LOAD;
                    state_d = S_MEM;
                end else begin
                    // Control-flow and setx retire directly from EXEC.
                    pc_write = 1'b1;
                    state_d  = S_FETCH;
                    if (is_br) begin
                        pc_src = branch_taken ? 2'd1 : 2'd0;
                    end else if (is_j || is_jal) begin
                        pc_src     = 2'd2;
                        reg_write  = is_jal;
                        link_write = is_jal;
                    end else if (is_jr) begin
                        pc_src = 2'd3;
                    end else if (is_bex) begin
                        pc_src = bex_cond ? 2'd2 : 2'd0;
                    end else begin
                        reg_write    = 1'b1;
                        status_write = 1'b1;
                    end
                end
            end
            S_MEM: begin
                mem_read  = is_lw;
                mem_write = is_sw;
                if (mem_ready) begin
                    if (is_lw) begin
                        state_d = S_WB;
                    end else begin
                        pc_write = 1'b1;
                        state_d  = S_FETCH;
                    end
                end else if (cnt_q == '0) begin
                    mem_fault = 1'b1;
                    pc_write  = 1'b1;
                    state_d   = S_FETCH;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_MULDIV: begin
                if (cnt_q == '0) state_d = S_WB;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_WB: begin
                reg_write  = 1'b1;
                reg_dst    = is_r;
                mem_to_reg = is_lw;
                pc_write   = 1'b1;
                state_d    = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
        // Reset silences every strobe, including ir_write while FETCH sees instr_valid.
        if (!reset_n) begin
            ir_write     = 1'b0;
            pc_write     = 1'b0;
            pc_src       = 2'd0;
            reg_write    = 1'b0;
            reg_dst      = 1'b0;
            mem_to_reg   = 1'b0;
            alu_src_b    = 1'b0;
            link_write   = 1'b0;
            status_write = 1'b0;
            mem_read     = 1'b0;
            mem_write    = 1'b0;
            muldiv_start = 1'b0;
            illegal_op   = 1'b0;
            mem_fault    = 1'b0;
        end
    end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: a per-cycle instruction-level model checked every negedge,
// plus directed instruction runs with hand-computed cycle counts and strobe totals.
module tb_multicycle_control_unit;
    localparam int LAT = 4;
    localparam int TO  = 16;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [4:0] opcode, aluop;
    logic       instr_valid, mem_ready, branch_taken, bex_cond;
    logic       ir_write, pc_write, reg_write, reg_dst, mem_to_reg, alu_src_b;
    logic       link_write, status_write, mem_read, mem_write, muldiv_start;
    logic       illegal_op, mem_fault, busy;
    logic [1:0] pc_src;
    logic [2:0] state;

    multicycle_control_unit #(.OPCODE_W(5), .MULDIV_LAT(LAT), .MEM_TIMEOUT(TO)) dut (
        .clock(clock), .reset_n(reset_n), .opcode(opcode), .aluop(aluop),
        .instr_valid(instr_valid), .mem_ready(mem_ready), .branch_taken(branch_taken),
        .bex_cond(bex_cond), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_b(alu_src_b), .link_write(link_write), .status_write(status_write),
        .mem_read(mem_read), .mem_write(mem_write), .muldiv_start(muldiv_start),
        .illegal_op(illegal_op), .mem_fault(mem_fault), .busy(busy), .state(state));

    always #5 clock = ~clock;

    typedef struct packed {
        logic ir, pcw; logic [1:0] src;
        logic rw, rd, m2r, asb, link, stw, mr, mw, ms, ill, mf, busy;
        logic [2:0] st;
    } outs_t;

    outs_t dut_o, exp_o;
    assign dut_o = {ir_write, pc_write, pc_src, reg_write, reg_dst, mem_to_reg, alu_src_b,
                    link_write, status_write, mem_read, mem_write, muldiv_start,
                    illegal_op, mem_fault, busy, state};

    int n_cmp = 0, n_fail = 0, n_cyc = 0;

    // Instruction kinds as the model sees them.
    localparam int K_R = 0, K_MD = 1, K_J = 2, K_BR = 3, K_JAL = 4, K_JR = 5, K_ADDI = 6,
                   K_SW = 7, K_LW = 8, K_SETX = 9, K_BEX = 10, K_ILL = 11;

    function automatic int classify(input logic [4:0] op, input logic [4:0] al);
        case (op)
            5'd0:  return (al == 5'd6 || al == 5'd7) ? K_MD : K_R;
            5'd1:  return K_J;
            5'd2:  return K_BR;
            5'd3:  return K_JAL;
            5'd4:  return K_JR;
            5'd5:  return K_ADDI;
            5'd6:  return K_BR;
            5'd7:  return K_SW;
            5'd8:  return K_LW;
            5'd21: return K_SETX;
            5'd22: return K_BEX;
            default: return K_ILL;
        endcase
    endfunction

    // Model: phase = the spec's state number, spent = cycles already spent in MEM/MULDIV.
    int m_ph = 0, m_kind = K_ILL, m_spent = 0;
    int nm_ph = 0, nm_kind = K_ILL, nm_spent = 0;

    always @(negedge clock) begin
        exp_o    = '0;
        nm_ph    = m_ph;
        nm_kind  = m_kind;
        nm_spent = m_spent;
        if (!reset_n) begin
            nm_ph = 0; nm_spent = 0;
        end else begin
            exp_o.st   = 3'(m_ph);
            exp_o.busy = (m_ph != 0);
            case (m_ph)
                0: if (instr_valid) begin
                    exp_o.ir = 1; nm_kind = classify(opcode, aluop); nm_ph = 1;
                end
                1: if (m_kind == K_ILL) begin
                    exp_o.ill = 1; exp_o.pcw = 1; nm_ph = 0;
                end else nm_ph = 2;
                2: begin
                    exp_o.asb = (m_kind == K_ADDI || m_kind == K_LW || m_kind == K_SW);
                    case (m_kind)
                        K_R, K_ADDI: nm_ph = 4;
                        K_MD:  begin exp_o.ms = 1; nm_spent = 0; nm_ph = 5; end
                        K_LW, K_SW: begin nm_spent = 0; nm_ph = 3; end
                        K_BR:  begin exp_o.pcw = 1; exp_o.src = branch_taken ? 2'd1 : 2'd0; nm_ph = 0; end
                        K_J:   begin exp_o.pcw = 1; exp_o.src = 2; nm_ph = 0; end
                        K_JAL: begin exp_o.pcw = 1; exp_o.src = 2; exp_o.rw = 1; exp_o.link = 1; nm_ph = 0; end
                        K_JR:  begin exp_o.pcw = 1; exp_o.src = 3; nm_ph = 0; end
                        K_BEX: begin exp_o.pcw = 1; exp_o.src = bex_cond ? 2'd2 : 2'd0; nm_ph = 0; end
                        default: begin exp_o.pcw = 1; exp_o.rw = 1; exp_o.stw = 1; nm_ph = 0; end
                    endcase
                end
                3: begin
                    exp_o.mr = (m_kind == K_LW);
                    exp_o.mw = (m_kind == K_SW);
                    if (mem_ready) begin
                        if (m_kind == K_LW) nm_ph = 4;
                        else begin exp_o.pcw = 1; nm_ph = 0; end
                    end else if (m_spent == TO - 1) begin
                        exp_o.mf = 1; exp_o.pcw = 1; nm_ph = 0;
                    end else nm_spent = m_spent + 1;
                end
                4: begin
                    exp_o.rw = 1; exp_o.pcw = 1;
                    exp_o.rd = (m_kind == K_R || m_kind == K_MD);
                    exp_o.m2r = (m_kind == K_LW);
                    nm_ph = 0;
                end
                default: begin
                    if (m_spent == LAT - 1) nm_ph = 4;
                    else nm_spent = m_spent + 1;
                end
            endcase
        end
        n_cmp++;
        n_cyc++;
        if (dut_o !== exp_o) begin
            n_fail++;
            if (n_fail < 30)
                $display("FAIL outs t=%0t got=%h exp=%h (state got %0d exp %0d)",
                         $time, dut_o, exp_o, dut_o.st, exp_o.st);
        end
    end

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_ph <= 0; m_spent <= 0;
        end else begin
            m_ph <= nm_ph; m_kind <= nm_kind; m_spent <= nm_spent;
        end
    end

    task automatic chk(input string nm, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    int r_cyc, r_seq, r_pcw, r_src, r_rw, r_rd, r_mr, r_mw, r_m2r, r_mem, r_md, r_ms, r_ill, r_flt, r_fltat, r_link;

    // Issue one instruction from FETCH; mem_ready pulses on MEM cycle ready_at (0 = never).
    task automatic run_instr(input logic [4:0] op, input logic [4:0] al, input int ready_at,
                             input logic bt, input logic bc, input int stop_after);
        r_cyc = 0; r_seq = 0; r_pcw = 0; r_src = -1; r_rw = 0; r_rd = 0; r_mr = 0; r_mw = 0;
        r_m2r = 0; r_mem = 0; r_md = 0; r_ms = 0; r_ill = 0; r_flt = 0; r_fltat = 0; r_link = 0;
        @(posedge clock); #1;
        opcode = op; aluop = al; instr_valid = 1'b1; branch_taken = bt; bex_cond = bc;
        for (int c = 1; c <= 60; c++) begin
            if (c > 1) begin @(posedge clock); #1; instr_valid = 1'b0; end
            mem_ready = (ready_at > 0 && c == 3 + ready_at);
            @(negedge clock);
            if (c > 1 && state == 3'd0) begin r_cyc = c - 1; return; end
            r_seq = (r_seq << 4) | int'(state);
            if (pc_write) begin r_pcw++; r_src = int'(pc_src); end
            r_rw += int'(reg_write); r_rd += int'(reg_dst); r_mr += int'(mem_read);
            r_mw += int'(mem_write); r_m2r += int'(mem_to_reg); r_ms += int'(muldiv_start);
            r_ill += int'(illegal_op); r_link += int'(link_write);
            if (state == 3'd3) r_mem++;
            if (state == 3'd5) r_md++;
            if (mem_fault) begin r_flt++; r_fltat = r_mem; end
            if (c == stop_after) return;
        end
        chk("instr_timeout", 0, 1);
    endtask

    initial begin
        reset_n = 1'b0; opcode = 5'd5; aluop = '0; instr_valid = 1'b1;
        mem_ready = 1'b1; branch_taken = 1'b1; bex_cond = 1'b1;
        #2;
        chk("reset_state", int'(state), 0);
        chk("reset_outs", int'(dut_o), 0);
        @(posedge clock); #1;
        chk("reset_ir_write", int'(ir_write), 0);
        instr_valid = 1'b0; mem_ready = 1'b0;
        @(posedge clock); #1 reset_n = 1'b1;

        run_instr(5'd5, 5'd0, 0, 0, 0, 0);       // addi
        chk("addi_cycles", r_cyc, 4);
        chk("addi_seq", r_seq, 32'h0124);
        chk("addi_rw", r_rw, 1);
        chk("addi_pcw", r_pcw, 1);
        chk("addi_src", r_src, 0);

        run_instr(5'd2, 5'd0, 0, 1, 0, 0);       // bne taken
        chk("bne_t_cycles", r_cyc, 3);
        chk("bne_t_src", r_src, 1);
        chk("bne_t_rw", r_rw, 0);
        run_instr(5'd2, 5'd0, 0, 0, 0, 0);       // bne not taken
        chk("bne_n_src", r_src, 0);
        chk("bne_n_rw", r_rw, 0);

        run_instr(5'd8, 5'd0, 3, 0, 0, 0);       // lw, ready on 3rd MEM cycle
        chk("lw_cycles", r_cyc, 7);
        chk("lw_mem_read", r_mr, 3);
        chk("lw_m2r", r_m2r, 1);
        chk("lw_rw", r_rw, 1);
        chk("lw_pcw", r_pcw, 1);

        run_instr(5'd7, 5'd0, 0, 0, 0, 0);       // sw, never ready
        chk("sw_to_cycles", r_cyc, 19);
        chk("sw_to_fault", r_flt, 1);
        chk("sw_to_fault_at", r_fltat, 16);
        chk("sw_to_mw", r_mw, 16);
        chk("sw_to_pcw", r_pcw, 1);
        chk("sw_to_rw", r_rw, 0);

        run_instr(5'd7, 5'd0, 1, 0, 0, 0);       // sw, ready immediately
        chk("sw_cycles", r_cyc, 4);

        run_instr(5'd0, 5'd6, 0, 0, 0, 0);       // mul
        chk("mul_cycles", r_cyc, 8);
        chk("mul_seq", r_seq, 32'h01255554);
        chk("mul_start", r_ms, 1);
        chk("mul_md", r_md, 4);
        chk("mul_rd", r_rd, 1);

        run_instr(5'd3, 5'd0, 0, 0, 0, 0);       // jal
        chk("jal_src", r_src, 2);
        chk("jal_link", r_link, 1);

        run_instr(5'd31, 5'd0, 0, 0, 0, 0);      // illegal
        chk("ill_cycles", r_cyc, 2);
        chk("ill_pulse", r_ill, 1);
        chk("ill_pcw", r_pcw, 1);
        chk("ill_src", r_src, 0);

        run_instr(5'd8, 5'd0, 0, 0, 0, 6);       // lw stalled 3 MEM cycles, then reset
        chk("rst_mem_seq", r_seq, 32'h012333);
        @(posedge clock); #1 reset_n = 1'b0;
        #1;
        chk("rst_mem_state", int'(state), 0);
        chk("rst_mem_outs", int'(dut_o), 0);
        @(posedge clock); #1 reset_n = 1'b1;
        run_instr(5'd5, 5'd0, 0, 0, 0, 0);
        chk("post_rst_cycles", r_cyc, 4);
        chk("post_rst_seq", r_seq, 32'h0124);

        // Random traffic, checked cycle by cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clock); #1;
            reset_n      = ($urandom_range(0, 299) != 0);
            instr_valid  = ($urandom_range(0, 9) < 6);
            mem_ready    = ($urandom_range(0, 3) == 0);
            branch_taken = 1'($urandom);
            bex_cond     = 1'($urandom);
            aluop        = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(6, 7)) : 5'($urandom);
            case ($urandom_range(0, 11))
                0: opcode = 5'd0;  1: opcode = 5'd1;  2: opcode = 5'd2;  3: opcode = 5'd3;
                4: opcode = 5'd4;  5: opcode = 5'd5;  6: opcode = 5'd6;  7: opcode = 5'd7;
                8: opcode = 5'd8;  9: opcode = 5'd21; 10: opcode = 5'd22;
                default: opcode = 5'($urandom);
            endcase
        end
        @(posedge clock); #1;
        reset_n = 1'b1; instr_valid = 1'b0;
        @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
